fetch_sequencer: RTL and testbench

- Owns the architectural PC and sequences instruction fetch for the five-stage pipeline.
- Chooses the next fetch address from three sources: sequential PC+4, the EX-stage branch/jump redirect (pc_sel/branch_target from the branch unit), or a hold during stall.
- Runs a valid/ready handshake to instruction memory and generates the IF/ID and ID/EX squash signals.
- Halts on ecall/ebreak or a misaligned redirect target.

---
 rtl/fetch_sequencer_if.sv | 12 +
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch request bus: sequencer (master) drives the address and
// request, instruction memory (slave) answers with ready.
interface fetch_sequencer_if #(
  parameter int PC_W = 9
);
  logic            fetch_req;
  logic [PC_W-1:0] fetch_addr;
  logic            fetch_ready;

  modport master (output fetch_req, output fetch_addr, input fetch_ready);
  modport slave  (input fetch_req, input fetch_addr, output fetch_ready);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, picks the next fetch address
// (sequential, EX redirect, or hold), handshakes with instruction memory and
// generates the IF/ID and ID/EX squash signals. Stops on halt or on a
// misaligned redirect target until reset.
module fetch_sequencer #(
  parameter int          PC_W     = 9,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_target,
  input  logic                halt_req,
  fetch_sequencer_if.master   fbus,
  output logic                flush_if_id,
  output logic                flush_id_ex,
  output logic                halted,
  output logic                misalign_err,
  output logic [15:0]         redirect_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            mis_q, mis_d;
  logic            cnt_inc;

  // Target decode: only the low PC_W bits form the address, only [1:0]
  // decide alignment; the upper target bits are intentionally dropped.
  logic            tgt_aligned;
  logic [PC_W-1:0] tgt_pc;
  logic            unused_tgt_hi;

  assign tgt_aligned   = (redirect_target[1:0] == 2'b00);
  assign tgt_pc        = redirect_target[PC_W-1:0];
  assign unused_tgt_hi = ^redirect_target[31:PC_W];

  // State, PC, pending target and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      pend_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state, next-PC and flush decode. Priority inside RUN/HOLD is
  // halt > misaligned redirect > aligned redirect > stall > sequential.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    mis_d       = mis_q;
    cnt_inc     = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;

    unique case (state_q)
      IDLE: begin
        // One dead cycle after reset before the first request.
        state_d = RUN;
      end

      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (redirect_valid && !tgt_aligned) begin
          mis_d   = 1'b1;
          state_d = HALTED;
        end else if (redirect_valid) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          cnt_inc     = 1'b1;
          if (fbus.fetch_ready) begin
            pc_d = tgt_pc;
          end else begin
            // Memory has not taken the current address; it must stay put,
            // so park the target until the transfer completes.
            pend_d  = tgt_pc;
            state_d = HOLD;
          end
        end else if (stall) begin
          pc_d = pc_q;
        end else if (fbus.fetch_ready) begin
          pc_d = pc_q + PC_INC;
        end
      end

      HOLD: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (redirect_valid && !tgt_aligned) begin
          mis_d   = 1'b1;
          state_d = HALTED;
        end else if (redirect_valid) begin
          // A younger redirect supersedes the parked one.
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          cnt_inc     = 1'b1;
          if (fbus.fetch_ready) begin
            pc_d    = tgt_pc;
            state_d = RUN;
          end else begin
            pend_d = tgt_pc;
          end
        end else if (fbus.fetch_ready) begin
          // The stale instruction fetched at the old pc is squashed.
          pc_d        = pend_q;
          state_d     = RUN;
          flush_if_id = 1'b1;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating redirect counter.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign fbus.fetch_req  = (state_q == RUN) || (state_q == HOLD);
  assign fbus.fetch_addr = pc_q;
  assign halted          = (state_q == HALTED);
  assign misalign_err    = mis_q;
  assign redirect_cnt    = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a flag-based reference model of the PC rules.
module tb_fetch_sequencer;

  localparam int PC_W = 9;
  localparam logic [PC_W-1:0] PC_MASK = '1;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        halted;
  logic        misalign_err;
  logic [15:0] redirect_cnt;

  fetch_sequencer_if #(.PC_W(PC_W)) fbus ();

  fetch_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .fbus            (fbus),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .redirect_cnt    (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: abstract flags, not the DUT's encoding.
  bit        m_started;
  bit        m_halted;
  bit        m_pending;
  int        m_pc;
  int        m_pend;
  int        m_cnt;
  bit        m_mis;
  bit        prev_req;
  bit        prev_rdy;
  logic [PC_W-1:0] prev_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_pending = 0;
    m_pc = 0; m_pend = 0; m_cnt = 0; m_mis = 0;
    prev_req = 0; prev_rdy = 0; prev_addr = '0;
  endtask

  // Drive one cycle's inputs (called just after a rising edge), check all
  // outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cycle(input bit st, input bit rv, input logic [31:0] rt,
                       input bit hr, input bit rdy);
    bit exp_req, ok, take, hold_exit;
    stall = st; redirect_valid = rv; redirect_target = rt;
    halt_req = hr; fbus.fetch_ready = rdy;
    @(negedge clk);
    exp_req   = m_started && !m_halted;
    ok        = (rt[1:0] == 2'b00);
    take      = exp_req && rv && ok && !hr;
    hold_exit = exp_req && m_pending && rdy && !hr && !rv;
    chk("fetch_req",   fbus.fetch_req, exp_req);
    chk("fetch_addr",  fbus.fetch_addr, m_pc);
    chk("flush_if_id", flush_if_id, take || hold_exit);
    chk("flush_id_ex", flush_id_ex, take);
    chk("halted",      halted, m_halted);
    chk("misalign",    misalign_err, m_mis);
    chk("redir_cnt",   redirect_cnt, m_cnt);
    if (prev_req && !prev_rdy && fbus.fetch_req)
      chk("addr_stable", fbus.fetch_addr, prev_addr);
    prev_req  = fbus.fetch_req;
    prev_rdy  = rdy;
    prev_addr = fbus.fetch_addr;
    @(posedge clk);
    if (!m_started) begin
      m_started = 1;
    end else if (!m_halted) begin
      if (hr) begin
        m_halted = 1;
      end else if (rv && !ok) begin
        m_mis = 1; m_halted = 1;
      end else if (rv) begin
        if (m_cnt < 65535) m_cnt++;
        if (rdy) begin
          m_pc = int'(rt) & int'(PC_MASK); m_pending = 0;
        end else begin
          m_pend = int'(rt) & int'(PC_MASK); m_pending = 1;
        end
      end else if (m_pending) begin
        if (rdy) begin m_pc = m_pend; m_pending = 0; end
      end else if (!st && rdy) begin
        m_pc = (m_pc + 4) % (1 << PC_W);
      end
    end
    #1;
  endtask

  // Reset held across a rising edge, released just after it.
  task automatic do_reset();
    rst_n = 1'b0;
    stall = 0; redirect_valid = 0; redirect_target = '0; halt_req = 0;
    fbus.fetch_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic seq(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 0, rdy);
  endtask

  initial begin
    rst_n = 1'b0;
    #3;
    do_reset();

    // Sequential fetch from reset, one IDLE cycle, then wrap 0x1FC -> 0x000.
    cycle(0, 0, 32'h0, 0, 1);
    seq(128, 1);
    chk("wrap_to_zero", fbus.fetch_addr, 32'h0);
    seq(4, 1);

    // Redirect accepted directly at pc 0x010.
    chk("pc_at_010", fbus.fetch_addr, 32'h10);
    cycle(0, 1, 32'h0000_0040, 0, 1);
    chk("redir_addr", fbus.fetch_addr, 32'h40);
    chk("redir_cnt1", redirect_cnt, 32'd1);

    // Redirect parked in HOLD while memory is not ready.
    cycle(0, 1, 32'h0000_0020, 0, 1);
    cycle(0, 1, 32'h0000_0080, 0, 0);
    cycle(1, 0, 32'h0, 0, 0);
    cycle(0, 0, 32'h0, 0, 0);
    cycle(0, 0, 32'h0, 0, 1);
    chk("hold_exit_addr", fbus.fetch_addr, 32'h80);

    // Redirect beats stall, then stall alone holds the address.
    cycle(1, 1, 32'hFFFF_F100, 0, 1);
    chk("stall_redir", fbus.fetch_addr, 32'h100);
    cycle(1, 0, 32'h0, 0, 1);
    cycle(1, 0, 32'h0, 0, 1);
    cycle(1, 0, 32'h0, 0, 1);
    chk("stall_hold", fbus.fetch_addr, 32'h100);

    // Misaligned target halts, counter untouched, inputs then ignored.
    cycle(0, 1, 32'h0000_0042, 0, 1);
    chk("mis_halted", halted, 32'd1);
    chk("mis_cnt", redirect_cnt, 32'd4);
    for (int i = 0; i < 6; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom_range(0, 1), 1);

    // halt_req beats a simultaneous redirect.
    do_reset();
    seq(3, 1);
    cycle(0, 1, 32'h0000_0040, 1, 1);
    seq(3, 1);

    // Asynchronous reset pulse in the middle of HOLD.
    do_reset();
    seq(3, 1);
    cycle(0, 1, 32'h0000_0060, 0, 0);
    redirect_valid = 1'b1; redirect_target = 32'h0000_0010;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   fbus.fetch_req, 32'd0);
    chk("arst_addr",  fbus.fetch_addr, 32'd0);
    chk("arst_flush", {flush_if_id, flush_id_ex}, 32'd0);
    chk("arst_cnt",   redirect_cnt, 32'd0);
    chk("arst_halt",  {halted, misalign_err}, 32'd0);
    do_reset();
    seq(2, 1);

    // Random traffic with periodic resets to escape HALTED.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rt;
      rt = $urandom;
      if ($urandom_range(0, 15) != 0) rt[1:0] = 2'b00;
      if (i % 250 == 0) do_reset();
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, rt,
            $urandom_range(0, 79) == 0, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
